// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an RV32I instruction into ALU control and operands
// and holds them in a single-entry valid/ready pipeline register with stall and flush.
module alu_issue_stage #(
  parameter int D_WIDTH = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [D_WIDTH-1:0] pc,
  input  logic [D_WIDTH-1:0] rs1_data,
  input  logic [D_WIDTH-1:0] rs2_data,
  input  logic               flush,
  input  logic               out_ready,
  output logic               ex_valid,
  output logic [2:0]         ex_aluctrl,
  output logic [D_WIDTH-1:0] ex_aluop1,
  output logic [D_WIDTH-1:0] ex_aluop2,
  output logic [D_WIDTH-1:0] ex_store_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_regwrite,
  output logic               ex_branch,
  output logic               ex_branch_ne,
  output logic               ex_illegal
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [RADDR_W-1:0] rd_field;

  // Signed views of the immediate fields; the size casts below sign-extend them.
  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [31:0] imm_u32;
  logic [D_WIDTH-1:0] imm_i;
  logic [D_WIDTH-1:0] imm_s;
  logic [D_WIDTH-1:0] imm_u;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_field = instr[7 +: RADDR_W];
  assign imm_i12  = instr[31:20];
  assign imm_s12  = {instr[31:25], instr[11:7]};
  assign imm_u32  = {instr[31:12], 12'b0000_0000_0000};
  assign imm_i    = D_WIDTH'(imm_i12);
  assign imm_s    = D_WIDTH'(imm_s12);
  assign imm_u    = D_WIDTH'(imm_u32);

  logic [2:0]         dec_aluctrl;
  logic [D_WIDTH-1:0] dec_op1;
  logic [D_WIDTH-1:0] dec_op2;
  logic               dec_wb_class;
  logic               dec_regwrite;
  logic               dec_branch;
  logic               dec_branch_ne;
  logic               dec_illegal;

  // Instruction decode: ALU code, operand selection and side-band flags.
  always_comb begin
    dec_aluctrl   = ALU_ADD;
    dec_op1       = '0;
    dec_op2       = '0;
    dec_wb_class  = 1'b0;
    dec_regwrite  = 1'b0;
    dec_branch    = 1'b0;
    dec_branch_ne = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        dec_op1      = rs1_data;
        dec_op2      = rs2_data;
        dec_wb_class = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin
              dec_aluctrl = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              dec_aluctrl = ALU_SUB;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          3'b111: begin
            if (funct7 == F7_BASE) dec_aluctrl = ALU_AND;
            else                   dec_illegal = 1'b1;
          end
          3'b110: begin
            if (funct7 == F7_BASE) dec_aluctrl = ALU_OR;
            else                   dec_illegal = 1'b1;
          end
          3'b010: begin
            if (funct7 == F7_BASE) dec_aluctrl = ALU_SLT;
            else                   dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec_op1      = rs1_data;
        dec_op2      = imm_i;
        dec_wb_class = 1'b1;
        case (funct3)
          3'b000:  dec_aluctrl = ALU_ADD;
          3'b111:  dec_aluctrl = ALU_AND;
          3'b110:  dec_aluctrl = ALU_OR;
          3'b010:  dec_aluctrl = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec_op1      = rs1_data;
        dec_op2      = imm_i;
        dec_wb_class = 1'b1;
        if (funct3 == 3'b010) dec_aluctrl = ALU_ADD;
        else                  dec_illegal = 1'b1;
      end
      OP_STORE: begin
        dec_op1 = rs1_data;
        dec_op2 = imm_s;
        if (funct3 == 3'b010) dec_aluctrl = ALU_ADD;
        else                  dec_illegal = 1'b1;
      end
      OP_BRANCH: begin
        dec_aluctrl = ALU_SUB;
        dec_op1     = rs1_data;
        dec_op2     = rs2_data;
        dec_branch  = 1'b1;
        case (funct3)
          3'b000:  dec_branch_ne = 1'b0;
          3'b001:  dec_branch_ne = 1'b1;
          default: dec_illegal   = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec_op2      = imm_u;
        dec_wb_class = 1'b1;
      end
      OP_AUIPC: begin
        dec_op1      = pc;
        dec_op2      = imm_u;
        dec_wb_class = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal entry is still issued, but as an inert ADD 0,0 with no side effects.
    if (dec_illegal) begin
      dec_aluctrl   = ALU_ADD;
      dec_op1       = '0;
      dec_op2       = '0;
      dec_regwrite  = 1'b0;
      dec_branch    = 1'b0;
      dec_branch_ne = 1'b0;
    end else begin
      dec_regwrite = dec_wb_class & (rd_field != '0);
    end
  end

  logic               ex_valid_q,      ex_valid_d;
  logic [2:0]         ex_aluctrl_q,    ex_aluctrl_d;
  logic [D_WIDTH-1:0] ex_aluop1_q,     ex_aluop1_d;
  logic [D_WIDTH-1:0] ex_aluop2_q,     ex_aluop2_d;
  logic [D_WIDTH-1:0] ex_store_data_q, ex_store_data_d;
  logic [RADDR_W-1:0] ex_rd_q,         ex_rd_d;
  logic               ex_regwrite_q,   ex_regwrite_d;
  logic               ex_branch_q,     ex_branch_d;
  logic               ex_branch_ne_q,  ex_branch_ne_d;
  logic               ex_illegal_q,    ex_illegal_d;

  logic load;
  logic consume;

  assign in_ready = (~ex_valid_q | out_ready) & ~flush;
  assign load     = in_valid & in_ready;
  assign consume  = ex_valid_q & out_ready;

  // Pipeline register next state: flush beats load, load beats consume, else hold.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_aluctrl_d    = ex_aluctrl_q;
    ex_aluop1_d     = ex_aluop1_q;
    ex_aluop2_d     = ex_aluop2_q;
    ex_store_data_d = ex_store_data_q;
    ex_rd_d         = ex_rd_q;
    ex_regwrite_d   = ex_regwrite_q;
    ex_branch_d     = ex_branch_q;
    ex_branch_ne_d  = ex_branch_ne_q;
    ex_illegal_d    = ex_illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (load) begin
      ex_valid_d      = 1'b1;
      ex_aluctrl_d    = dec_aluctrl;
      ex_aluop1_d     = dec_op1;
      ex_aluop2_d     = dec_op2;
      ex_store_data_d = rs2_data;
      ex_rd_d         = rd_field;
      ex_regwrite_d   = dec_regwrite;
      ex_branch_d     = dec_branch;
      ex_branch_ne_d  = dec_branch_ne;
      ex_illegal_d    = dec_illegal;
    end else if (consume) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // ID/EX entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_aluctrl_q    <= 3'b000;
      ex_aluop1_q     <= '0;
      ex_aluop2_q     <= '0;
      ex_store_data_q <= '0;
      ex_rd_q         <= '0;
      ex_regwrite_q   <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_branch_ne_q  <= 1'b0;
      ex_illegal_q    <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_aluctrl_q    <= ex_aluctrl_d;
      ex_aluop1_q     <= ex_aluop1_d;
      ex_aluop2_q     <= ex_aluop2_d;
      ex_store_data_q <= ex_store_data_d;
      ex_rd_q         <= ex_rd_d;
      ex_regwrite_q   <= ex_regwrite_d;
      ex_branch_q     <= ex_branch_d;
      ex_branch_ne_q  <= ex_branch_ne_d;
      ex_illegal_q    <= ex_illegal_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_aluctrl    = ex_aluctrl_q;
  assign ex_aluop1     = ex_aluop1_q;
  assign ex_aluop2     = ex_aluop2_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_rd         = ex_rd_q;
  assign ex_regwrite   = ex_regwrite_q;
  assign ex_branch     = ex_branch_q;
  assign ex_branch_ne  = ex_branch_ne_q;
  assign ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push expected entries,
// a negedge monitor pops and compares every entry the EX stage consumes.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_ready;
  logic        ex_valid;
  logic [2:0]  ex_aluctrl;
  logic [31:0] ex_aluop1;
  logic [31:0] ex_aluop2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_branch;
  logic        ex_branch_ne;
  logic        ex_illegal;

  alu_issue_stage #(.D_WIDTH(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_ready(out_ready), .ex_valid(ex_valid),
    .ex_aluctrl(ex_aluctrl), .ex_aluop1(ex_aluop1), .ex_aluop2(ex_aluop2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        bne;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   popped = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] c, input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] s, input logic [4:0] r, input logic w,
                              input logic b, input logic n, input logic i);
    exp_t e;
    e.ctrl = c; e.op1 = o1; e.op2 = o2; e.sd = s; e.rd = r;
    e.rw = w; e.br = b; e.bne = n; e.ill = i;
    return e;
  endfunction

  function automatic exp_t actual();
    return {ex_aluctrl, ex_aluop1, ex_aluop2, ex_store_data, ex_rd,
            ex_regwrite, ex_branch, ex_branch_ne, ex_illegal};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_entry(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every entry consumed by EX must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && ex_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry: got %h, required none", actual());
      end else begin
        check_entry($sformatf("entry%0d", popped), actual(), q.pop_front());
        popped++;
      end
    end
  end

  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t e, input bit push);
    bit got;
    int n;
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = in_ready;
      n++;
    end
    if (got) begin
      if (push) q.push_back(e);
    end else begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: got in_ready=0 for 20 cycles, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  exp_t ea;
  exp_t eb;
  int   n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0000_0000; pc = 32'h0000_0000;
    rs1_data = 32'h0000_0000; rs2_data = 32'h0000_0000; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_entry("reset_fields", actual(), '0);
    check_bit("reset_valid", ex_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back decode vectors with EX always ready.
    issue(32'h402081B3, 32'h0, 32'd10, 32'd3,
          mk(3'b001, 32'd10, 32'd3, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'hFFF00093, 32'h0, 32'd0, 32'h55,
          mk(3'b000, 32'd0, 32'hFFFFFFFF, 32'h55, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h12345297, 32'h100, 32'h77, 32'h88,
          mk(3'b000, 32'h100, 32'h12345000, 32'h88, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h00112223, 32'h0, 32'h1000, 32'hDEADBEEF,
          mk(3'b000, 32'h1000, 32'd4, 32'hDEADBEEF, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h00209463, 32'h0, 32'd7, 32'd9,
          mk(3'b001, 32'd7, 32'd9, 32'd9, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    issue(32'h0000007F, 32'h0, 32'h11, 32'h22,
          mk(3'b000, 32'd0, 32'd0, 32'h22, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(32'hABCDE3B7, 32'h40, 32'h33, 32'h44,
          mk(3'b000, 32'd0, 32'hABCDE000, 32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h0062F233, 32'h0, 32'hF0F0, 32'h0FF0,
          mk(3'b010, 32'hF0F0, 32'h0FF0, 32'h0FF0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h0050A113, 32'h0, 32'hFFFFFFFE, 32'd1,
          mk(3'b101, 32'hFFFFFFFE, 32'd5, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h00208033, 32'h0, 32'd6, 32'd8,
          mk(3'b000, 32'd6, 32'd8, 32'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h4020E1B3, 32'h0, 32'd6, 32'd8,
          mk(3'b000, 32'd0, 32'd0, 32'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(32'h0080A283, 32'h0, 32'h200, 32'h5,
          mk(3'b000, 32'h200, 32'd8, 32'h5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    issue(32'h00208063, 32'h0, 32'd4, 32'd4,
          mk(3'b001, 32'd4, 32'd4, 32'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    issue(32'h0020A063, 32'h0, 32'd4, 32'd5,
          mk(3'b000, 32'd0, 32'd0, 32'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Stall for three cycles, then release: old entry leaves as the new one loads.
    out_ready = 1'b0;
    ea = mk(3'b010, 32'hF0F0, 32'h0FF0, 32'h0FF0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    eb = mk(3'b001, 32'd10, 32'd3, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'h0062F233, 32'h0, 32'hF0F0, 32'h0FF0, ea, 1'b1);
    instr = 32'h402081B3; rs1_data = 32'd10; rs2_data = 32'd3; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit($sformatf("stall_in_ready%0d", k), in_ready, 1'b0);
      check_bit($sformatf("stall_valid%0d", k), ex_valid, 1'b1);
      check_entry($sformatf("stall_hold%0d", k), actual(), ea);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("release_in_ready", in_ready, 1'b1);
    q.push_back(eb);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("no_bubble_valid", ex_valid, 1'b1);
    @(posedge clk); #1;

    // Flush kills the held entry and blocks the incoming one.
    out_ready = 1'b0;
    issue(32'h00208033, 32'h0, 32'd1, 32'd2, '0, 1'b0);
    instr = 32'h0062F233; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_bit("flush_in_ready", in_ready, 1'b0);
    check_bit("flush_held_valid", ex_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_bit("flush_valid", ex_valid, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset while an entry is stalled.
    issue(32'h402081B3, 32'h0, 32'd10, 32'd3, '0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("pre_reset_valid", ex_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_reset_valid", ex_valid, 1'b0);
    check_bit("async_reset_ctrl_zero", (ex_aluctrl == 3'b000), 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check_bit("post_reset_in_ready", in_ready, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d entries outstanding, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
